// File: rtl/load_data_extender.sv
// load_data_extender
//   Load-path formatter between the data-memory read port and the register
//   file write-back mux. Picks the addressed byte/half/word/dword lane out of
//   a read beat, sign- or zero-extends it to 64 bits and presents it on a
//   registered valid/ready output. On a 32-bit bus a doubleword load is
//   assembled from two consecutive beats (low word first).
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   en           1 = format/extend, 0 = pass raw beat through zero-extended
//   in_valid     input beat valid
//   in_ready     block can take a beat this cycle
//   in_data      memory read beat (DATA_W bits)
//   in_offset    byte offset of the access within the beat
//   in_size      00 byte, 01 half, 10 word, 11 doubleword
//   in_signed    1 = sign-extend, 0 = zero-extend
//   out_valid    out_data holds a completed load
//   out_ready    consumer takes out_data
//   out_data     64-bit formatted result
//   out_misalign result came from a misaligned request
module load_data_extender #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HI   = 2'b01,
    ST_FULL = 2'b10
  } state_t;

  localparam bit              NARROW    = (DATA_W == 32);
  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  state_t       state_r;
  state_t       next_state_s;
  logic [31:0]  lo_r;
  logic         lo_misalign_r;
  logic [63:0]  out_data_r;
  logic         out_misalign_r;

  logic         in_ready_s;
  logic         out_valid_s;
  logic         in_fire_s;
  logic         dword_first_s;
  logic [7:0]   byte_s;
  logic [15:0]  half_s;
  logic [31:0]  word_s;
  logic [63:0]  lane_s;
  logic [63:0]  result_s;
  logic         misalign_s;

  // Copies the MSB of the selected width into all higher bits when signed.
  function automatic logic [63:0] extend(input logic [63:0] v,
                                         input logic [1:0]  sz,
                                         input logic        sgn);
    case (sz)
      2'b00:   extend = {{56{sgn & v[7]}},  v[7:0]};
      2'b01:   extend = {{48{sgn & v[15]}}, v[15:0]};
      2'b10:   extend = {{32{sgn & v[31]}}, v[31:0]};
      2'b11:   extend = v;
      default: extend = v;
    endcase
  endfunction

  assign in_fire_s     = in_valid & in_ready_s;
  // Only the first beat of a dword on a 32-bit bus needs a second beat.
  assign dword_first_s = NARROW & en & (in_size == 2'b11);

  // Lane extraction: data is taken from the offset aligned down to the size.
  assign byte_s = 8'(in_data >> {in_offset, 3'b000});
  assign half_s = 16'(in_data >> {(in_offset & HALF_MASK), 3'b000});
  assign word_s = 32'(in_data >> {(in_offset & WORD_MASK), 3'b000});

  // Single-beat result formatting and misalignment detection.
  always_comb begin
    lane_s     = 64'(in_data);
    result_s   = 64'(in_data);
    misalign_s = 1'b0;
    if (en) begin
      case (in_size)
        2'b00: begin
          lane_s     = 64'(byte_s);
          misalign_s = 1'b0;
        end
        2'b01: begin
          lane_s     = 64'(half_s);
          misalign_s = in_offset[0];
        end
        2'b10: begin
          lane_s     = 64'(word_s);
          misalign_s = |in_offset[1:0];
        end
        2'b11: begin
          lane_s     = 64'(in_data);
          misalign_s = |in_offset;
        end
        default: begin
          lane_s     = 64'(in_data);
          misalign_s = 1'b0;
        end
      endcase
      result_s = extend(lane_s, in_size, in_signed);
    end else begin
      result_s   = 64'(in_data);
      misalign_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_fire_s) begin
          next_state_s = dword_first_s ? ST_HI : ST_FULL;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HI: begin
        if (in_fire_s) begin
          next_state_s = ST_FULL;
        end else begin
          next_state_s = ST_HI;
        end
      end
      ST_FULL: begin
        if (in_fire_s) begin
          next_state_s = dword_first_s ? ST_HI : ST_FULL;
        end else if (out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FULL;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready_s  = 1'b1;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_HI: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_FULL: begin
        // A new beat can only enter when the current result leaves.
        in_ready_s  = out_ready;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State, held low word and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      lo_r           <= 32'd0;
      lo_misalign_r  <= 1'b0;
      out_data_r     <= 64'd0;
      out_misalign_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (in_fire_s) begin
        if (state_r == ST_HI) begin
          // High beat: its size/signed/offset are don't-care.
          out_data_r     <= {in_data[31:0], lo_r};
          out_misalign_r <= lo_misalign_r;
        end else if (dword_first_s) begin
          lo_r          <= in_data[31:0];
          lo_misalign_r <= |in_offset;
        end else begin
          out_data_r     <= result_s;
          out_misalign_r <= misalign_s;
        end
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_s;
  assign out_data     = out_data_r;
  assign out_misalign = out_misalign_r;

endmodule

// File: tb/tb_load_data_extender.sv
module tb_load_data_extender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_offset;
  logic [1:0]  in_size;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_data_extender #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_offset(in_offset), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misalign(out_misalign)
  );

  // Reference: {misalign, data} for a single-beat load, from arithmetic rules.
  function automatic logic [64:0] ref_single(input logic [31:0] d, input int off,
                                             input int size, input bit sgn, input bit e);
    logic [63:0] val, mask;
    int nb, al;
    if (!e) return {1'b0, 32'h0, d};
    nb   = 1 << size;
    if (nb > 4) nb = 4;
    al   = off - (off % nb);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    val  = ({32'h0, d} >> (8 * al)) & mask;
    if (sgn && val[8 * nb - 1]) val = val | ~mask;
    return {((off % nb) != 0), val};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic [1:0] off,
                        input logic [1:0] sz, input logic sg, input logic e);
    in_valid = v; in_data = d; in_offset = off; in_size = sz; in_signed = sg; en = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    cycle(); cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_misalign !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h mis=%b rdy=%b want 0/0/0/1",
               out_valid, out_data, out_misalign, in_ready);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_byte_signed();
    set_in(1'b1, 32'h0000_8000, 2'd1, 2'b00, 1'b1, 1'b1);
    out_ready = 1'b1;
    cycle();
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_FFFF_FF80 || out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL byte_signed: valid=%b data=%h mis=%b want 1/ffffffffffffff80/0",
               out_valid, out_data, out_misalign);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_half_back_to_back();
    out_ready = 1'b1;
    set_in(1'b1, 32'hBEEF_1234, 2'd2, 2'b01, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 32'hBEEF_1234, 2'd3, 2'b01, 1'b0, 1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_0000_BEEF || out_misalign !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL half_unsigned: valid=%b data=%h mis=%b rdy=%b want 1/beef/0/1",
               out_valid, out_data, out_misalign, in_ready);
    end
    cycle();
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_0000_BEEF || out_misalign !== 1'b1) begin
      errors++;
      $display("FAIL half_misaligned: valid=%b data=%h mis=%b want 1/beef/1",
               out_valid, out_data, out_misalign);
    end
    cycle();
  endtask

  task automatic test_dword();
    out_ready = 1'b1;
    set_in(1'b1, 32'h1111_1111, 2'd0, 2'b11, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dword_lo_ready: rdy=%b want 1", in_ready);
    end
    cycle();
    // High beat carries unrelated size/signed/offset that must be ignored.
    set_in(1'b1, 32'h8000_0000, 2'd3, 2'b00, 1'b1, 1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dword_hi_state: valid=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    cycle();
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h8000_0000_1111_1111 || out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL dword_result: valid=%b data=%h mis=%b want 1/8000000011111111/0",
               out_valid, out_data, out_misalign);
    end
    cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_in(1'b1, 32'hFFFF_FFFF, 2'd0, 2'b10, 1'b1, 1'b1);
    cycle();
    set_in(1'b1, 32'h0000_007F, 2'd0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_FFFF_FFFF || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b data=%h rdy=%b want 1/ffffffffffffffff/0",
                 i, out_valid, out_data, in_ready);
      end
      cycle();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: rdy=%b want 1", in_ready);
    end
    cycle();
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_0000_007F) begin
      errors++;
      $display("FAIL backpressure_next: valid=%b data=%h want 1/7f", out_valid, out_data);
    end
    cycle();
  endtask

  task automatic test_reset_in_hi();
    out_ready = 1'b1;
    set_in(1'b1, 32'hAAAA_AAAA, 2'd0, 2'b11, 1'b0, 1'b1);
    cycle();
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_in_hi: valid=%b rdy=%b data=%h want 0/1/0", out_valid, in_ready, out_data);
    end
    set_in(1'b1, 32'h0000_0055, 2'd0, 2'b00, 1'b0, 1'b1);
    cycle();
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_0000_0055) begin
      errors++;
      $display("FAIL after_reset_byte: valid=%b data=%h want 1/55", out_valid, out_data);
    end
    cycle();
  endtask

  task automatic test_bypass();
    out_ready = 1'b1;
    set_in(1'b1, 32'h8000_0001, 2'd0, 2'b00, 1'b1, 1'b0);
    cycle();
    // Bypassed dword request is a single beat with no misalign flag.
    set_in(1'b1, 32'hC0DE_0001, 2'd1, 2'b11, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_8000_0001 || out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL bypass_byte: valid=%b data=%h mis=%b want 1/80000001/0",
               out_valid, out_data, out_misalign);
    end
    cycle();
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_C0DE_0001 || out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL bypass_dword: valid=%b data=%h mis=%b want 1/c0de0001/0",
               out_valid, out_data, out_misalign);
    end
    cycle();
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    logic        mis_q[$];
    bit          have_lo = 1'b0;
    logic [31:0] lo_data = 32'h0;
    bit          lo_mis  = 1'b0;
    logic [64:0] r;
    bit          exp_ready, ofire, ifire;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL random_valid[%0d]: valid=%b want %b", i, out_valid, exp_q.size() != 0);
      end else if (exp_q.size() != 0 && (out_data !== exp_q[0] || out_misalign !== mis_q[0])) begin
        errors++;
        $display("FAIL random_data[%0d]: data=%h mis=%b want %h/%b",
                 i, out_data, out_misalign, exp_q[0], mis_q[0]);
      end
      set_in(1'($urandom_range(0, 3) != 0), $urandom, 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      exp_ready = have_lo || (exp_q.size() == 0) || out_ready;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL random_ready[%0d]: rdy=%b want %b", i, in_ready, exp_ready);
      end
      ofire = (exp_q.size() != 0) && out_ready;
      ifire = in_valid && exp_ready;
      if (ofire) begin
        void'(exp_q.pop_front());
        void'(mis_q.pop_front());
      end
      if (ifire) begin
        if (have_lo) begin
          exp_q.push_back({in_data, lo_data});
          mis_q.push_back(lo_mis);
          have_lo = 1'b0;
        end else if (en && in_size == 2'b11) begin
          have_lo = 1'b1;
          lo_data = in_data;
          lo_mis  = (in_offset != 2'd0);
        end else begin
          r = ref_single(in_data, int'(in_offset), int'(in_size), in_signed, en);
          exp_q.push_back(r[63:0]);
          mis_q.push_back(r[64]);
        end
      end
      @(negedge clk);
    end
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    test_reset();
    test_byte_signed();
    test_half_back_to_back();
    test_dword();
    test_backpressure();
    test_reset_in_hi();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
